// File: rtl/ttm4_pkg.sv
// rtl/ttm4_pkg.sv - shared types and constants for the TTM4 cycle sequencer
package ttm4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_ACK,
        ST_HALTED
    } state_t;

    localparam logic [3:0] E_ENABLED  = 4'b0100;
    localparam logic [3:0] E_DISABLED = 4'b0001;
    localparam int         PHASE_W    = 3;

    function automatic logic is_active(input state_t s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/ttm4_tick_div.sv
// rtl/ttm4_tick_div.sv - loadable down-counter producing a one-cycle phase tick
module ttm4_tick_div #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    // div is only sampled at a reload, so a change waits for the next tick or start
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (start) begin
            count <= div;
        end else if (enable) begin
            if (count == '0) begin
                count <= div;
            end else begin
                count <= count - DIV_W'(1);
            end
        end
    end

    assign tick = enable && (count == '0);

endmodule

// File: rtl/ttm4_cycle_sequencer.sv
// rtl/ttm4_cycle_sequencer.sv - machine-cycle sequencer driving the phase decoder A/E inputs
module ttm4_cycle_sequencer
    import ttm4_pkg::*;
#(
    parameter int N_PHASES = 8,
    parameter int DIV_W    = 20
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [DIV_W-1:0] DIV,
    input  logic             RUN,
    input  logic             STEP_REQ,
    output logic             STEP_ACK,
    input  logic             HALT,
    output logic [3:0]       A,
    output logic [3:0]       E,
    output logic             PHASE_TICK,
    output logic             CYCLE_END,
    output logic             BUSY,
    output logic             HALTED
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(N_PHASES - 1);

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [3:0]         e_q;
    logic               phase_tick_q, cycle_end_q, busy_q, halted_q, step_ack_q;
    logic               phase_tick_d, cycle_end_d, div_start, tick;

    ttm4_tick_div #(.DIV_W(DIV_W)) u_tick_div (
        .clk    (CLK),
        .rst    (RST),
        .enable (is_active(state_q)),
        .start  (div_start),
        .div    (DIV),
        .tick   (tick)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        phase_tick_d = 1'b0;
        cycle_end_d  = 1'b0;
        div_start    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (RUN) begin
                    state_d   = ST_RUN;
                    phase_d   = '0;
                    div_start = 1'b1;
                end else if (STEP_REQ) begin
                    state_d   = ST_STEP;
                    phase_d   = '0;
                    div_start = 1'b1;
                end
            end
            ST_RUN, ST_STEP: begin
                if (tick) begin
                    phase_tick_d = 1'b1;
                    if (phase_q == LAST_PHASE) begin
                        // End-of-cycle decisions are only taken on the wrapping tick
                        phase_d     = '0;
                        cycle_end_d = 1'b1;
                        if (HALT) begin
                            state_d = ST_HALTED;
                        end else if (state_q == ST_RUN) begin
                            state_d = RUN ? ST_RUN : ST_IDLE;
                        end else begin
                            state_d = ST_ACK;
                        end
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end
            end
            ST_ACK: begin
                if (!STEP_REQ) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (!RUN && !STEP_REQ) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            e_q          <= E_DISABLED;
            phase_tick_q <= 1'b0;
            cycle_end_q  <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            step_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            e_q          <= is_active(state_d) ? E_ENABLED : E_DISABLED;
            phase_tick_q <= phase_tick_d;
            cycle_end_q  <= cycle_end_d;
            busy_q       <= is_active(state_d);
            halted_q     <= (state_d == ST_HALTED);
            step_ack_q   <= (state_d == ST_ACK);
        end
    end

    assign A          = {1'b0, phase_q};
    assign E          = e_q;
    assign PHASE_TICK = phase_tick_q;
    assign CYCLE_END  = cycle_end_q;
    assign BUSY       = busy_q;
    assign HALTED     = halted_q;
    assign STEP_ACK   = step_ack_q;

endmodule

// File: tb/tb_ttm4_cycle_sequencer.sv
// tb/tb_ttm4_cycle_sequencer.sv - self-checking bench for ttm4_cycle_sequencer
module tb_ttm4_cycle_sequencer;

    localparam logic [3:0] EN  = 4'b0100;
    localparam logic [3:0] DIS = 4'b0001;

    logic        CLK = 1'b0;
    logic        RST;
    logic [19:0] DIV;
    logic        RUN, STEP_REQ, HALT;

    logic        STEP_ACK, PHASE_TICK, CYCLE_END, BUSY, HALTED;
    logic [3:0]  A, E;
    logic        STEP_ACK3, PHASE_TICK3, CYCLE_END3, BUSY3, HALTED3;
    logic [3:0]  A3, E3;

    int checks   = 0;
    int failures = 0;

    // {A, E, PHASE_TICK, CYCLE_END, BUSY, HALTED, STEP_ACK}
    logic [12:0] obs, obs3;
    assign obs  = {A, E, PHASE_TICK, CYCLE_END, BUSY, HALTED, STEP_ACK};
    assign obs3 = {A3, E3, PHASE_TICK3, CYCLE_END3, BUSY3, HALTED3, STEP_ACK3};

    always #5 CLK = ~CLK;

    ttm4_cycle_sequencer #(.N_PHASES(8), .DIV_W(20)) dut (
        .CLK(CLK), .RST(RST), .DIV(DIV), .RUN(RUN), .STEP_REQ(STEP_REQ),
        .STEP_ACK(STEP_ACK), .HALT(HALT), .A(A), .E(E), .PHASE_TICK(PHASE_TICK),
        .CYCLE_END(CYCLE_END), .BUSY(BUSY), .HALTED(HALTED)
    );

    ttm4_cycle_sequencer #(.N_PHASES(3), .DIV_W(20)) dut3 (
        .CLK(CLK), .RST(RST), .DIV(DIV), .RUN(RUN), .STEP_REQ(STEP_REQ),
        .STEP_ACK(STEP_ACK3), .HALT(HALT), .A(A3), .E(E3), .PHASE_TICK(PHASE_TICK3),
        .CYCLE_END(CYCLE_END3), .BUSY(BUSY3), .HALTED(HALTED3)
    );

    // Expected outputs c clocks after entering an active cycle, before it ends
    function automatic logic [12:0] model_active(input int c, input int d, input int n);
        int per, len;
        logic [3:0] a;
        logic pt, ce;
        per = d + 1;
        len = per * n;
        a   = 4'((c / per) % n);
        pt  = (c > 0) && (c % per == 0);
        ce  = (c > 0) && (c % len == 0);
        return {a, EN, pt, ce, 1'b1, 1'b0, 1'b0};
    endfunction

    task automatic tick_clk();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; DIV = '0; RUN = 1'b0; STEP_REQ = 1'b0; HALT = 1'b0;
        tick_clk();
        tick_clk();
        checks++;
        if (obs !== {4'h0, DIS, 5'b0}) begin
            failures++; $display("FAIL reset_state got=%h exp=%h", obs, {4'h0, DIS, 5'b0});
        end
        checks++;
        if (obs3 !== {4'h0, DIS, 5'b0}) begin
            failures++; $display("FAIL reset_state_n3 got=%h exp=%h", obs3, {4'h0, DIS, 5'b0});
        end
        RST = 1'b0;
        tick_clk();
        checks++;
        if (obs !== {4'h0, DIS, 5'b0}) begin
            failures++; $display("FAIL idle_after_reset got=%h exp=%h", obs, {4'h0, DIS, 5'b0});
        end
    endtask

    task automatic test_free_run(input int d);
        int len, drop_c;
        len    = (d + 1) * 8;
        drop_c = 3 * len + 3 * (d + 1);
        DIV = 20'(d); RUN = 1'b1; STEP_REQ = 1'b0; HALT = 1'b0;
        tick_clk();
        for (int c = 0; c < 4 * len; c++) begin
            checks++;
            if (obs !== model_active(c, d, 8)) begin
                failures++;
                $display("FAIL free_run d=%0d c=%0d got=%h exp=%h", d, c, obs, model_active(c, d, 8));
            end
            if (c == drop_c) begin
                RUN = 1'b0; STEP_REQ = 1'b0;
            end else if (c < drop_c) begin
                STEP_REQ = 1'($urandom % 2);
            end
            tick_clk();
        end
        checks++;
        if (obs !== {4'h0, DIS, 5'b11000}) begin
            failures++; $display("FAIL free_run_end got=%h exp=%h", obs, {4'h0, DIS, 5'b11000});
        end
        tick_clk();
        checks++;
        if (obs !== {4'h0, DIS, 5'b0}) begin
            failures++; $display("FAIL free_run_idle got=%h exp=%h", obs, {4'h0, DIS, 5'b0});
        end
    endtask

    task automatic test_step(input int d);
        int len, hold;
        len  = (d + 1) * 8;
        hold = $urandom_range(4, 12);
        DIV = 20'(d); RUN = 1'b0; STEP_REQ = 1'b1; HALT = 1'b0;
        tick_clk();
        for (int c = 0; c < len; c++) begin
            checks++;
            if (obs !== model_active(c, d, 8)) begin
                failures++;
                $display("FAIL step d=%0d c=%0d got=%h exp=%h", d, c, obs, model_active(c, d, 8));
            end
            tick_clk();
        end
        checks++;
        if (obs !== {4'h0, DIS, 5'b11001}) begin
            failures++; $display("FAIL step_end got=%h exp=%h", obs, {4'h0, DIS, 5'b11001});
        end
        for (int i = 0; i < hold; i++) begin
            tick_clk();
            checks++;
            if (obs !== {4'h0, DIS, 5'b00001}) begin
                failures++; $display("FAIL step_ack_hold i=%0d got=%h exp=%h", i, obs, {4'h0, DIS, 5'b00001});
            end
        end
        STEP_REQ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            checks++;
            if (obs !== {4'h0, DIS, 5'b0}) begin
                failures++; $display("FAIL step_release i=%0d got=%h exp=%h", i, obs, {4'h0, DIS, 5'b0});
            end
        end
    endtask

    task automatic test_halt(input int d);
        int len;
        len = (d + 1) * 8;
        DIV = 20'(d); RUN = 1'b1; STEP_REQ = 1'b0; HALT = 1'b0;
        tick_clk();
        for (int c = 0; c < len; c++) begin
            checks++;
            if (obs !== model_active(c, d, 8)) begin
                failures++;
                $display("FAIL halt_cycle d=%0d c=%0d got=%h exp=%h", d, c, obs, model_active(c, d, 8));
            end
            HALT = (c / (d + 1) == 2) || (c / (d + 1) == 7);
            tick_clk();
        end
        checks++;
        if (obs !== {4'h0, DIS, 5'b11010}) begin
            failures++; $display("FAIL halt_entry got=%h exp=%h", obs, {4'h0, DIS, 5'b11010});
        end
        HALT = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i >= 4) RUN = 1'b0;
            STEP_REQ = (i >= 4) ? 1'b1 : 1'($urandom % 2);
            tick_clk();
            checks++;
            if (obs !== {4'h0, DIS, 5'b00010}) begin
                failures++; $display("FAIL halt_hold i=%0d got=%h exp=%h", i, obs, {4'h0, DIS, 5'b00010});
            end
        end
        STEP_REQ = 1'b0;
        tick_clk();
        checks++;
        if (obs !== {4'h0, DIS, 5'b0}) begin
            failures++; $display("FAIL halt_release got=%h exp=%h", obs, {4'h0, DIS, 5'b0});
        end
    endtask

    task automatic test_reset_mid();
        DIV = '0; RUN = 1'b1; STEP_REQ = 1'b0; HALT = 1'b0;
        tick_clk();
        repeat (5) tick_clk();
        checks++;
        if (A !== 4'd5 || BUSY !== 1'b1) begin
            failures++; $display("FAIL reset_mid_pre got=%h exp_A=5 busy=1", obs);
        end
        RST = 1'b1; RUN = 1'b0;
        tick_clk();
        checks++;
        if (obs !== {4'h0, DIS, 5'b0}) begin
            failures++; $display("FAIL reset_mid got=%h exp=%h", obs, {4'h0, DIS, 5'b0});
        end
        RST = 1'b0;
        tick_clk();
        checks++;
        if (obs !== {4'h0, DIS, 5'b0}) begin
            failures++; $display("FAIL reset_mid_after got=%h exp=%h", obs, {4'h0, DIS, 5'b0});
        end
    endtask

    task automatic test_n3();
        RST = 1'b1; RUN = 1'b0; STEP_REQ = 1'b0; HALT = 1'b0; DIV = '0;
        tick_clk();
        RST = 1'b0; RUN = 1'b1;
        tick_clk();
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (obs3 !== model_active(c, 0, 3)) begin
                failures++;
                $display("FAIL n3_wrap c=%0d got=%h exp=%h", c, obs3, model_active(c, 0, 3));
            end
            if (c == 7) RUN = 1'b0;
            tick_clk();
        end
        checks++;
        if (obs3 !== {4'h0, DIS, 5'b11000}) begin
            failures++; $display("FAIL n3_end got=%h exp=%h", obs3, {4'h0, DIS, 5'b11000});
        end
    endtask

    initial begin
        test_reset();
        test_free_run(0);
        test_free_run($urandom_range(1, 3));
        test_step(2);
        test_step($urandom_range(0, 3));
        test_halt($urandom_range(0, 2));
        test_reset_mid();
        test_n3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
